ramb_asym_dp_sc: RTL and testbench
==================================

# ramb_asym_dp_sc

Parametrised single-clock, true-dual-port block RAM with asymmetric port widths, selectable per-port read-during-write mode, an optional output pipeline register and deterministic cross-port collision handling with a collision monitor. It generalises the fixed-ratio two-clock block RAM cells. It is the standard storage primitive for width-converting buffers and lookup tables in the single-clock-domain parts of the design.

## Interface
Parameters:
- A_WIDTH, 2: port A data width; power of two, 1..32.
- B_WIDTH, 4: port B data width; power of two, >= A_WIDTH, <= 32.
- MEM_BITS, 4096: total storage bits; power of two, >= B_WIDTH.
- A_ADDR_W, log2(MEM_BITS/A_WIDTH): derived, 11 with defaults; not to be overridden.
- B_ADDR_W, log2(MEM_BITS/B_WIDTH): derived, 10 with defaults; not to be overridden.
- WRITE_MODE_A, 0: port A read-during-write mode: 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE.
- WRITE_MODE_B, 0: same encoding, for port B.
- DO_REG, 0: 1 adds one output register stage on both ports.
- INIT_FILE, "": hex file loaded at time zero; empty means all zeros.

Ports:
- CLK, in, 1: the single clock; all state changes on its rising edge.
- RST_N, in, 1: asynchronous, active-low reset.
- ENA, in, 1: port A enable.
- WEA, in, 1: port A write enable; qualified by ENA.
- ADDRA, in, A_ADDR_W: port A word address.
- DIA, in, A_WIDTH: port A write data.
- DOA, out, A_WIDTH: port A read data.
- ENB, in, 1: port B enable.
- WEB, in, 1: port B write enable; qualified by ENB.
- ADDRB, in, B_ADDR_W: port B word address.
- DIB, in, B_WIDTH: port B write data.
- DOB, out, B_WIDTH: port B read data.
- COLL, out, 1: one-cycle pulse flagging a cross-port collision.
- COLL_CNT, out, 8: saturating count of collisions.

## Operation
- Bit mapping:
  - Port A word i occupies mem[i*A_WIDTH +: A_WIDTH].
  - Port B word j occupies mem[j*B_WIDTH +: B_WIDTH].
  - LSB-first, matching the existing INIT bit order.
- RATIO = B_WIDTH/A_WIDTH. The ports overlap when (ADDRA >> log2(RATIO)) == ADDRB. The overlapping A slice within the B word is ADDRA[log2(RATIO)-1:0].
- A port with EN=1 and WE=0 is a read: the stage-1 output loads the addressed word.
- A port with EN=1 and WE=1 is a write: memory is updated. The stage-1 output depends on the write mode:
  - WRITE_FIRST: output loads DI.
  - READ_FIRST: output loads the old word.
  - NO_CHANGE: output holds.
- A port with EN=0 holds its stage-1 output, and memory is untouched.
- Collision: both ports enabled, ports overlap, and at least one WE=1.
  - Write/write: port A wins on the overlapping A_WIDTH bits. The remaining B bits take DIB.
  - Write/read: the reading port returns the pre-write contents.
  - Any collision pulses COLL the next cycle and increments COLL_CNT. COLL_CNT saturates at 255.
- The writing port's own output follows its own write mode, including under collision.
- DO_REG=1:
  - Per port, a valid bit records that stage 1 was loaded in the previous cycle.
  - Stage 2 (DOA/DOB) loads from stage 1 only when that valid bit is set; otherwise it holds.
- RST_N low, asynchronously:
  - Cleared: DOA, DOB, stage-1 and stage-2 registers, valid bits, COLL, COLL_CNT.
  - Memory contents are retained.

## Timing
- Read latency, from the EN-sampling edge:
  - DO_REG=0: data on DOx after that edge (1 cycle).
  - DO_REG=1: data after the following edge (2 cycles).
- Write data is visible to either port on a read issued the cycle after the write.
- COLL is asserted for exactly one cycle, on the edge following the colliding cycle.
- COLL_CNT updates on that same edge.
- Back-to-back collisions:
  - COLL stays high.
  - COLL_CNT increments every cycle until it reaches 255.
- Reset values: all outputs 0.
- Reset release:
  - The first edge with RST_N high is a normal operating edge.
  - Deassertion is synchronised externally.
- Reset asserted mid-pipeline (DO_REG=1) discards the in-flight read. No output change follows the release.

## Test plan
- Defaults, no collision:
  - Cycle 0: write A addr 5 = 2'b11, write A addr 4 = 2'b01.
  - Cycle 2: read B addr 2. Required: DOB = 4'b1101 one cycle later.
- Read-during-write modes, port B writes 4'hA over old 4'h3:
  - WRITE_FIRST: DOB = 4'hA.
  - READ_FIRST: DOB = 4'h3.
  - NO_CHANGE: DOB keeps its previous value.
- Write/write collision, mem word B1 = 4'h0:
  - Same cycle: A writes addr 3 = 2'b10, B writes addr 1 = 4'hF.
  - Required: readback B1 = 4'hB; COLL high for 1 cycle; COLL_CNT = 1.
- Write/read collision:
  - A writes addr 0 = 2'b11 while B reads addr 0, old value 4'h0.
  - Required: DOB = 4'h0; the next B read returns 4'h3; COLL pulses.
- Saturation and pipeline:
  - DO_REG=1, 260 consecutive collisions. Required: COLL_CNT stops at 255.
  - Read with ENA pulsed once. Required: DOA updates exactly 2 cycles later, then holds.
- Asynchronous reset:
  - Drop RST_N mid-cycle while DOA = 2'b11 and COLL_CNT = 7.
  - Required: both are 0 immediately, before the next edge; memory readback is unchanged after release.

Source files
------------

// File: rtl/ramb_asym_dp_sc.sv
// ramb_asym_dp_sc
// Single-clock true-dual-port block RAM with asymmetric port widths.
// Port A addresses A_WIDTH-bit words and port B addresses B_WIDTH-bit words
// of the same storage, LSB-first. Each port has its own read-during-write
// mode (0 write-first, 1 read-first, 2 no-change). DO_REG=1 adds one output
// register stage per port. Cross-port collisions are resolved
// deterministically and counted.
//
// Ports:
//   CLK              single clock, rising edge
//   RST_N            asynchronous active-low reset (outputs/pipeline only)
//   ENA/WEA          port A enable / write enable
//   ADDRA/DIA/DOA    port A word address, write data, read data
//   ENB/WEB          port B enable / write enable
//   ADDRB/DIB/DOB    port B word address, write data, read data
//   COLL             one-cycle pulse, the cycle after a cross-port collision
//   COLL_CNT         saturating collision count
module ramb_asym_dp_sc #(
  parameter int    A_WIDTH      = 2,
  parameter int    B_WIDTH      = 4,
  parameter int    MEM_BITS     = 4096,
  parameter int    A_ADDR_W     = $clog2(MEM_BITS / A_WIDTH),
  parameter int    B_ADDR_W     = $clog2(MEM_BITS / B_WIDTH),
  parameter int    WRITE_MODE_A = 0,
  parameter int    WRITE_MODE_B = 0,
  parameter int    DO_REG       = 0,
  parameter string INIT_FILE    = ""
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ENA,
  input  logic                WEA,
  input  logic [A_ADDR_W-1:0] ADDRA,
  input  logic [A_WIDTH-1:0]  DIA,
  output logic [A_WIDTH-1:0]  DOA,
  input  logic                ENB,
  input  logic                WEB,
  input  logic [B_ADDR_W-1:0] ADDRB,
  input  logic [B_WIDTH-1:0]  DIB,
  output logic [B_WIDTH-1:0]  DOB,
  output logic                COLL,
  output logic [7:0]          COLL_CNT
);

  localparam int WF      = 0;
  localparam int RF      = 1;
  localparam int NC      = 2;
  localparam int RATIO   = B_WIDTH / A_WIDTH;
  localparam int SEL_W   = $clog2(RATIO);
  localparam int SEL_WI  = (SEL_W > 0) ? SEL_W : 1;
  localparam int DEPTH_B = MEM_BITS / B_WIDTH;

  // Storage is organised as B-width words; port A works on a slice of one.
  logic [B_WIDTH-1:0] mem [DEPTH_B];

  // Split the A address into the containing B word and the slice inside it.
  logic [B_ADDR_W-1:0] a_word;
  logic [SEL_WI-1:0]   a_sel;

  generate
    if (SEL_W > 0) begin : g_split
      assign a_word = ADDRA[A_ADDR_W-1:SEL_W];
      assign a_sel  = ADDRA[SEL_W-1:0];
    end else begin : g_nosplit
      assign a_word = ADDRA;
      assign a_sel  = '0;
    end
  endgenerate

  // Pre-write contents seen by both ports this cycle.
  logic [B_WIDTH-1:0] rd_a_word;
  logic [A_WIDTH-1:0] rd_a;
  logic [B_WIDTH-1:0] rd_b;

  assign rd_a_word = mem[a_word];
  assign rd_a      = rd_a_word[a_sel*A_WIDTH +: A_WIDTH];
  assign rd_b      = mem[ADDRB];

  // Port B is written first so port A's slice write lands on top of it,
  // giving A priority on the overlapping bits of a write/write collision.
  always_ff @(posedge CLK) begin
    if (ENB && WEB) begin
      mem[ADDRB] <= DIB;
    end
    if (ENA && WEA) begin
      mem[a_word][a_sel*A_WIDTH +: A_WIDTH] <= DIA;
    end
  end

  // Stage-1 output registers.
  logic [A_WIDTH-1:0] s1_a_reg;
  logic [B_WIDTH-1:0] s1_b_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_a_reg <= '0;
      s1_b_reg <= '0;
    end else begin
      if (ENA) begin
        if (!WEA || WRITE_MODE_A == RF) begin
          s1_a_reg <= rd_a;
        end else if (WRITE_MODE_A == WF) begin
          s1_a_reg <= DIA;
        end
      end
      if (ENB) begin
        if (!WEB || WRITE_MODE_B == RF) begin
          s1_b_reg <= rd_b;
        end else if (WRITE_MODE_B == WF) begin
          s1_b_reg <= DIB;
        end
      end
    end
  end

  generate
    if (DO_REG != 0) begin : g_oreg
      logic               vld_a_reg;
      logic               vld_b_reg;
      logic [A_WIDTH-1:0] s2_a_reg;
      logic [B_WIDTH-1:0] s2_b_reg;

      // Valid marks a stage-1 load; a no-change write does not load.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          vld_a_reg <= 1'b0;
          vld_b_reg <= 1'b0;
          s2_a_reg  <= '0;
          s2_b_reg  <= '0;
        end else begin
          vld_a_reg <= ENA && !(WEA && WRITE_MODE_A == NC);
          vld_b_reg <= ENB && !(WEB && WRITE_MODE_B == NC);
          if (vld_a_reg) begin
            s2_a_reg <= s1_a_reg;
          end
          if (vld_b_reg) begin
            s2_b_reg <= s1_b_reg;
          end
        end
      end

      assign DOA = s2_a_reg;
      assign DOB = s2_b_reg;
    end else begin : g_noreg
      assign DOA = s1_a_reg;
      assign DOB = s1_b_reg;
    end
  endgenerate

  // Collision monitor.
  logic       coll_next;
  logic       coll_reg;
  logic [7:0] coll_cnt_reg;

  assign coll_next = ENA && ENB && (a_word == ADDRB) && (WEA || WEB);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      coll_reg     <= 1'b0;
      coll_cnt_reg <= 8'd0;
    end else begin
      coll_reg <= coll_next;
      if (coll_next && coll_cnt_reg != 8'hFF) begin
        coll_cnt_reg <= coll_cnt_reg + 8'd1;
      end
    end
  end

  assign COLL     = coll_reg;
  assign COLL_CNT = coll_cnt_reg;

endmodule

// File: tb/tb_ramb_asym_dp_sc.sv
// Bench for ramb_asym_dp_sc. Four instances share one stimulus stream:
//   u[0] defaults (B write-first, DO_REG=0)
//   u[1] B read-first
//   u[2] B no-change
//   u[3] DO_REG=1
// Stimulus pushes expected outputs (with the cycle they are due) into a
// scoreboard queue; a monitor compares at each falling edge.
module tb_ramb_asym_dp_sc;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ENA = 1'b0;
  logic        WEA = 1'b0;
  logic [10:0] ADDRA = '0;
  logic [1:0]  DIA = '0;
  logic        ENB = 1'b0;
  logic        WEB = 1'b0;
  logic [9:0]  ADDRB = '0;
  logic [3:0]  DIB = '0;

  logic [1:0]  doa [4];
  logic [3:0]  dob [4];
  logic        coll [4];
  logic [7:0]  cnt [4];

  always #5 CLK = ~CLK;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      ramb_asym_dp_sc #(
        .WRITE_MODE_B(gi == 1 ? 1 : (gi == 2 ? 2 : 0)),
        .DO_REG      (gi == 3 ? 1 : 0)
      ) u (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .ENA     (ENA),
        .WEA     (WEA),
        .ADDRA   (ADDRA),
        .DIA     (DIA),
        .DOA     (doa[gi]),
        .ENB     (ENB),
        .WEB     (WEB),
        .ADDRB   (ADDRB),
        .DIB     (DIB),
        .DOB     (dob[gi]),
        .COLL    (coll[gi]),
        .COLL_CNT(cnt[gi])
      );
    end
  endgenerate

  localparam int S_DOA = 0;
  localparam int S_DOB = 1;
  localparam int S_COLL = 2;
  localparam int S_CNT = 3;

  typedef struct {
    int         due;
    int         inst;
    int         sig;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] get_out(input int inst, input int sig);
    case (sig)
      S_DOA:   return {6'd0, doa[inst]};
      S_DOB:   return {4'd0, dob[inst]};
      S_COLL:  return {7'd0, coll[inst]};
      default: return cnt[inst];
    endcase
  endfunction

  task automatic expect_at(input int due, input int inst, input int sig,
                           input logic [7:0] val, input string name);
    exp_t e;
    e.due = due; e.inst = inst; e.sig = sig; e.exp = val; e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every entry that is due this cycle.
  initial begin
    logic [7:0] act;
    forever begin
      @(negedge CLK);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          act = get_out(sb[i].inst, sb[i].sig);
          total++;
          if (act !== sb[i].exp) begin
            bad++;
            $display("FAIL %s u%0d sig%0d cyc%0d: got %0h want %0h",
                     sb[i].name, sb[i].inst, sb[i].sig, cyc, act, sb[i].exp);
          end else begin
            $display("ok   %s u%0d sig%0d cyc%0d: %0h",
                     sb[i].name, sb[i].inst, sb[i].sig, cyc, act);
          end
          sb.delete(i);
        end
      end
      if (done || cyc > 3000) begin
        if (!done) begin
          total++;
          bad++;
          $display("FAIL timeout: got cyc=%0d want done", cyc);
        end
        foreach (sb[i]) begin
          total++;
          bad++;
          $display("FAIL %s u%0d never checked: got none want %0h",
                   sb[i].name, sb[i].inst, sb[i].exp);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    ENA = 1'b0; WEA = 1'b0; ENB = 1'b0; WEB = 1'b0;
  endtask

  task automatic a_op(input logic we, input logic [10:0] addr, input logic [1:0] d);
    ENA = 1'b1; WEA = we; ADDRA = addr; DIA = d;
  endtask

  task automatic b_op(input logic we, input logic [9:0] addr, input logic [3:0] d);
    ENB = 1'b1; WEB = we; ADDRB = addr; DIB = d;
  endtask

  // Expect a DOA/DOB value on all instances: 1-cycle for u0..u2, 2 for u3.
  task automatic exp_data(input int t, input int sig, input logic [7:0] v,
                          input string name);
    for (int k = 0; k < 3; k++) expect_at(t + 1, k, sig, v, name);
    expect_at(t + 2, 3, sig, v, name);
  endtask

  task automatic exp_ctl(input int due, input int sig, input logic [7:0] v,
                         input string name);
    for (int k = 0; k < 4; k++) expect_at(due, k, sig, v, name);
  endtask

  initial begin
    int t;
    // Reset state.
    tick; tick;
    for (int s = 0; s < 4; s++) exp_ctl(cyc, s, 8'd0, "reset");
    RST_N = 1'b1;

    // Clear B words 0..3.
    for (int w = 0; w < 4; w++) begin
      idle; b_op(1'b1, 10'(w), 4'h0); tick;
    end

    // Two A writes, then a B read of the containing word.
    idle; a_op(1'b1, 11'd5, 2'b11); tick;
    idle; a_op(1'b1, 11'd4, 2'b01); tick;
    idle; b_op(1'b0, 10'd2, 4'h0); t = cyc; tick;
    exp_data(t, S_DOB, 8'hD, "asym_read");

    // Read-during-write on port B: A over old 3.
    idle; b_op(1'b1, 10'd3, 4'h3); tick;
    idle; b_op(1'b0, 10'd2, 4'h0); tick;
    idle; b_op(1'b1, 10'd3, 4'hA); t = cyc; tick;
    expect_at(t + 1, 0, S_DOB, 8'hA, "wf_write");
    expect_at(t + 1, 1, S_DOB, 8'h3, "rf_write");
    expect_at(t + 1, 2, S_DOB, 8'hD, "nc_write");
    expect_at(t + 1, 3, S_DOB, 8'hD, "pipe_prev");
    expect_at(t + 2, 3, S_DOB, 8'hA, "pipe_wf_write");
    idle; b_op(1'b0, 10'd3, 4'h0); t = cyc; tick;
    exp_data(t, S_DOB, 8'hA, "readback_3");

    // Write/write collision on B word 1.
    idle; a_op(1'b1, 11'd3, 2'b10); b_op(1'b1, 10'd1, 4'hF); t = cyc; tick;
    exp_ctl(t + 1, S_COLL, 8'd1, "ww_coll");
    exp_ctl(t + 1, S_CNT, 8'd1, "ww_cnt");
    exp_ctl(t + 2, S_COLL, 8'd0, "ww_coll_end");
    expect_at(t + 1, 0, S_DOA, 8'h2, "ww_doa_wf");
    expect_at(t + 1, 0, S_DOB, 8'hF, "ww_dob_wf");
    expect_at(t + 1, 1, S_DOB, 8'h0, "ww_dob_rf");
    idle; b_op(1'b0, 10'd1, 4'h0); t = cyc; tick;
    exp_data(t, S_DOB, 8'hB, "ww_readback");

    // Write/read collision on B word 0.
    idle; a_op(1'b1, 11'd0, 2'b11); b_op(1'b0, 10'd0, 4'h0); t = cyc; tick;
    exp_data(t, S_DOB, 8'h0, "wr_old");
    exp_ctl(t + 1, S_COLL, 8'd1, "wr_coll");
    exp_ctl(t + 1, S_CNT, 8'd2, "wr_cnt");
    exp_ctl(t + 2, S_COLL, 8'd0, "wr_coll_end");
    expect_at(t + 1, 0, S_DOA, 8'h3, "wr_doa_wf");
    idle; b_op(1'b0, 10'd0, 4'h0); t = cyc; tick;
    exp_data(t, S_DOB, 8'h3, "wr_readback");

    // 260 back-to-back collisions: counter saturates.
    for (int i = 1; i <= 260; i++) begin
      idle; a_op(1'b1, 11'd20, 2'b00); b_op(1'b0, 10'd10, 4'h0);
      if (i == 1 || i == 100 || i == 252 || i == 253 || i == 254 || i == 260) begin
        expect_at(cyc + 1, 0, S_CNT, 8'((2 + i > 255) ? 255 : 2 + i), "sat_cnt");
        expect_at(cyc + 1, 3, S_CNT, 8'((2 + i > 255) ? 255 : 2 + i), "sat_cnt");
        expect_at(cyc + 1, 3, S_COLL, 8'd1, "sat_coll");
      end
      tick;
    end
    idle;
    expect_at(cyc + 1, 3, S_COLL, 8'd0, "sat_coll_end");
    expect_at(cyc + 1, 3, S_CNT, 8'd255, "sat_hold");

    // Single ENA pulse through the output pipeline.
    a_op(1'b0, 11'd5, 2'b00); t = cyc; tick; idle;
    expect_at(t + 1, 0, S_DOA, 8'h3, "pulse_doa");
    expect_at(t + 1, 3, S_DOA, 8'h0, "pulse_early");
    expect_at(t + 2, 3, S_DOA, 8'h3, "pulse_lat2");
    expect_at(t + 3, 3, S_DOA, 8'h3, "pulse_hold");
    expect_at(t + 4, 3, S_DOA, 8'h3, "pulse_hold");
    tick; tick; tick; tick;

    // Build DOA=3, COLL_CNT=7, then drop reset mid-cycle.
    RST_N = 1'b0; tick; RST_N = 1'b1;
    for (int i = 0; i < 7; i++) begin
      idle; a_op(1'b1, 11'd20, 2'b00); b_op(1'b0, 10'd10, 4'h0); tick;
    end
    idle; a_op(1'b0, 11'd5, 2'b00); t = cyc; tick; idle;
    expect_at(t + 1, 0, S_DOA, 8'h3, "pre_rst_doa");
    expect_at(t + 1, 0, S_CNT, 8'd7, "pre_rst_cnt");
    tick;
    #2;
    RST_N = 1'b0;
    exp_ctl(cyc, S_DOA, 8'd0, "async_doa");
    exp_ctl(cyc, S_CNT, 8'd0, "async_cnt");
    exp_ctl(cyc, S_DOB, 8'd0, "async_dob");
    tick;
    RST_N = 1'b1;

    // Memory survives reset.
    idle; b_op(1'b0, 10'd2, 4'h0); a_op(1'b0, 11'd5, 2'b00); t = cyc; tick; idle;
    exp_data(t, S_DOB, 8'hD, "post_rst_b2");
    exp_data(t, S_DOA, 8'h3, "post_rst_a5");
    expect_at(t + 1, 3, S_DOA, 8'h0, "post_rst_quiet");
    exp_ctl(t + 1, S_CNT, 8'd0, "post_rst_cnt");
    b_op(1'b0, 10'd3, 4'h0); t = cyc; tick; idle;
    exp_data(t, S_DOB, 8'hA, "post_rst_b3");
    tick; tick; tick;
    done = 1'b1;
  end

endmodule
